// File: rtl/hazard_stall_controller_pkg.sv
// ============================================================================
// Module  : hazard_stall_controller_pkg
// Brief   : Shared encodings and helpers for the pipeline stall/flush control
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_stall_controller_pkg;

    localparam int c_reg_idx_w  = 5;
    localparam int c_wait_cnt_w = 8;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t c_ctrl_advance = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0, id_ex_write: 1'b1,
        id_ex_bubble: 1'b0, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};

    // Every register held and every downstream stage loaded with a NOP.
    localparam pipe_ctrl_t c_ctrl_reset = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1, id_ex_write: 1'b0,
        id_ex_bubble: 1'b1, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

    localparam pipe_ctrl_t c_ctrl_freeze = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b0,
        id_ex_bubble: 1'b0, ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

    localparam pipe_ctrl_t c_ctrl_flush = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1, id_ex_write: 1'b1,
        id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};

    localparam pipe_ctrl_t c_ctrl_loaduse = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0, id_ex_write: 1'b1,
        id_ex_bubble: 1'b1, ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};

    // A load into $0 writes nothing, so it can never create a dependency.
    function automatic logic detect_loaduse(
        input logic                   ex_mem_read,
        input logic [c_reg_idx_w-1:0] ex_rt,
        input logic [c_reg_idx_w-1:0] id_rs,
        input logic [c_reg_idx_w-1:0] id_rt,
        input logic                   id_uses_rt
    );
        return ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter that sticks at its all-ones value instead of wrapping
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_max = '1;

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module  : hazard_stall_controller
// Brief   : Load-use stall, branch flush and memory-wait freeze for a 5-stage pipe
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ID_EXMemRead,
    input  logic [c_reg_idx_w-1:0] ID_EXRegisterRt,
    input  logic [c_reg_idx_w-1:0] IF_IDRegisterRs,
    input  logic [c_reg_idx_w-1:0] IF_IDRegisterRt,
    input  logic                   IF_IDUsesRt,
    input  logic                   EXBranchTaken,
    input  logic                   EX_MEMMemAccess,
    input  logic                   DMemReady,
    output logic                   PCWrite,
    output logic                   IF_IDWrite,
    output logic                   IF_IDFlush,
    output logic                   ID_EXWrite,
    output logic                   ID_EXBubble,
    output logic                   EX_MEMWrite,
    output logic                   MEM_WBBubble,
    output logic                   MemWaitBusy,
    output logic                   MemTimeout,
    output logic [CNT_W-1:0]       StallCount,
    output logic [CNT_W-1:0]       FlushCount
);

    localparam logic [c_wait_cnt_w-1:0] c_timeout  = c_wait_cnt_w'(MEM_TIMEOUT);
    localparam logic [c_wait_cnt_w-1:0] c_wait_max = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_wait_cnt_w-1:0] r_wait_cnt;
    logic [c_wait_cnt_w-1:0] w_wait_cnt_nxt;
    logic                    r_timeout;
    logic                    w_timeout_nxt;

    logic       w_memstall;
    logic       w_loaduse;
    logic       w_freeze;
    logic       w_flush_evt;
    logic       w_stall_inc;
    pipe_ctrl_t w_ctrl;

    always_comb begin
        w_memstall  = EX_MEMMemAccess & ~DMemReady;
        w_loaduse   = detect_loaduse(ID_EXMemRead, ID_EXRegisterRt, IF_IDRegisterRs,
                                     IF_IDRegisterRt, IF_IDUsesRt);
        // Once waiting, only the memory's ready matters; the MEM instruction is frozen.
        w_freeze    = (r_state == RUN) ? w_memstall : ~DMemReady;
        w_flush_evt = ~rst & ~w_freeze & EXBranchTaken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            RUN: begin
                if (w_memstall) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = c_wait_cnt_w'(1);
                end
            end
            MEM_WAIT: begin
                if (DMemReady) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt != c_wait_max) begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
        // The flag is sticky; the FSM keeps waiting for the memory regardless.
        if ((w_state_nxt == MEM_WAIT) && (w_wait_cnt_nxt == c_timeout)) begin
            w_timeout_nxt = 1'b1;
        end
    end

    always_comb begin
        w_ctrl = c_ctrl_advance;
        if (rst) begin
            w_ctrl = c_ctrl_reset;
        end else if (w_freeze) begin
            w_ctrl = c_ctrl_freeze;
        end else if (EXBranchTaken) begin
            w_ctrl = c_ctrl_flush;
        end else if (w_loaduse) begin
            w_ctrl = c_ctrl_loaduse;
        end
    end

    assign PCWrite      = w_ctrl.pc_write;
    assign IF_IDWrite   = w_ctrl.if_id_write;
    assign IF_IDFlush   = w_ctrl.if_id_flush;
    assign ID_EXWrite   = w_ctrl.id_ex_write;
    assign ID_EXBubble  = w_ctrl.id_ex_bubble;
    assign EX_MEMWrite  = w_ctrl.ex_mem_write;
    assign MEM_WBBubble = w_ctrl.mem_wb_bubble;
    assign MemWaitBusy  = ~rst & (r_state == MEM_WAIT);
    assign MemTimeout   = r_timeout;

    assign w_stall_inc = ~rst & ~w_ctrl.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_evt),
        .count (FlushCount)
    );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// ============================================================================
// Module  : tb_hazard_stall_controller
// Brief   : Directed and randomized checks of hazard_stall_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             ID_EXMemRead;
    logic [4:0]       ID_EXRegisterRt;
    logic [4:0]       IF_IDRegisterRs;
    logic [4:0]       IF_IDRegisterRt;
    logic             IF_IDUsesRt;
    logic             EXBranchTaken;
    logic             EX_MEMMemAccess;
    logic             DMemReady;
    logic             PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble;
    logic             EX_MEMWrite, MEM_WBBubble, MemWaitBusy, MemTimeout;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic [7:0]       outs;

    int nchk = 0;
    int nbad = 0;

    // Reference state: plain integers following the written rules.
    bit m_wait;
    int m_wcnt, m_stall, m_flush;
    bit m_to;

    // Output bit order: PCWrite IF_IDWrite IF_IDFlush ID_EXWrite ID_EXBubble EX_MEMWrite MEM_WBBubble MemWaitBusy
    localparam logic [7:0] RST_OUT = 8'b0010_1010;
    localparam logic [7:0] DEF_OUT = 8'b1101_0100;
    localparam logic [7:0] LU_OUT  = 8'b0001_1100;

    assign outs = {PCWrite, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXBubble,
                   EX_MEMWrite, MEM_WBBubble, MemWaitBusy};

    hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_EXMemRead(ID_EXMemRead), .ID_EXRegisterRt(ID_EXRegisterRt),
        .IF_IDRegisterRs(IF_IDRegisterRs), .IF_IDRegisterRt(IF_IDRegisterRt),
        .IF_IDUsesRt(IF_IDUsesRt), .EXBranchTaken(EXBranchTaken),
        .EX_MEMMemAccess(EX_MEMMemAccess), .DMemReady(DMemReady),
        .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
        .ID_EXWrite(ID_EXWrite), .ID_EXBubble(ID_EXBubble), .EX_MEMWrite(EX_MEMWrite),
        .MEM_WBBubble(MEM_WBBubble), .MemWaitBusy(MemWaitBusy), .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_ctrl();
        bit ms, frz, lu;
        if (rst) return RST_OUT;
        ms  = EX_MEMMemAccess && !DMemReady;
        frz = m_wait ? !DMemReady : ms;
        lu  = ID_EXMemRead && (ID_EXRegisterRt != 0) &&
              ((ID_EXRegisterRt == IF_IDRegisterRs) ||
               (IF_IDUsesRt && (ID_EXRegisterRt == IF_IDRegisterRt)));
        if (frz)           return {7'b0000_001, m_wait};
        if (EXBranchTaken) return {7'b1111_110, m_wait};
        if (lu)            return {7'b0001_110, m_wait};
        return {7'b1101_010, m_wait};
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
    endtask

    task automatic model_edge();
        logic [7:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        c = model_ctrl();
        if (!c[7]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (c[5])  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        if (!m_wait) begin
            if (EX_MEMMemAccess && !DMemReady) begin
                m_wait = 1;
                m_wcnt = 1;
            end
        end else if (DMemReady) begin
            m_wait = 0;
            m_wcnt = 0;
        end else if (m_wcnt < 255) begin
            m_wcnt++;
        end
        if (m_wait && m_wcnt >= MEM_TIMEOUT) m_to = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        ID_EXMemRead = 0; ID_EXRegisterRt = 0; IF_IDRegisterRs = 0; IF_IDRegisterRt = 0;
        IF_IDUsesRt = 0; EXBranchTaken = 0; EX_MEMMemAccess = 0; DMemReady = 1;
    endtask

    task automatic do_rst();
        rst = 1;
        model_reset();
        tick();
        rst = 0;
        set_idle();
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        ID_EXMemRead = 1; ID_EXRegisterRt = 2; IF_IDRegisterRs = 2; EXBranchTaken = 1;
        model_reset();
        @(negedge clk);
        nchk++;
        if (outs !== RST_OUT) begin nbad++; $display("FAIL reset_ctrl: got %b want %b", outs, RST_OUT); end
        nchk++;
        if (StallCount !== 0 || FlushCount !== 0 || MemTimeout !== 1'b0) begin
            nbad++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d to=%b want 0 0 0", StallCount, FlushCount, MemTimeout);
        end
        tick();
        rst = 0;
        set_idle();
    endtask

    task automatic test_load_use();
        do_rst();
        ID_EXMemRead = 1; ID_EXRegisterRt = 3; IF_IDRegisterRs = 3;
        @(negedge clk);
        nchk++;
        if (outs !== LU_OUT) begin nbad++; $display("FAIL loaduse_ctrl: got %b want %b", outs, LU_OUT); end
        tick();
        ID_EXMemRead = 0; EX_MEMMemAccess = 1;
        @(negedge clk);
        nchk++;
        if (outs !== DEF_OUT) begin nbad++; $display("FAIL loaduse_resume: got %b want %b", outs, DEF_OUT); end
        nchk++;
        if (StallCount !== 1) begin nbad++; $display("FAIL loaduse_count: got %0d want 1", StallCount); end
        tick();
    endtask

    task automatic test_no_stall();
        do_rst();
        ID_EXMemRead = 1; ID_EXRegisterRt = 0; IF_IDRegisterRs = 0; IF_IDRegisterRt = 0; IF_IDUsesRt = 1;
        @(negedge clk);
        nchk++;
        if (outs !== DEF_OUT) begin nbad++; $display("FAIL rt_zero: got %b want %b", outs, DEF_OUT); end
        tick();
        ID_EXRegisterRt = 7; IF_IDRegisterRs = 2; IF_IDRegisterRt = 7; IF_IDUsesRt = 0;
        @(negedge clk);
        nchk++;
        if (outs !== DEF_OUT) begin nbad++; $display("FAIL rt_unused: got %b want %b", outs, DEF_OUT); end
        nchk++;
        if (StallCount !== 0) begin nbad++; $display("FAIL no_stall_count: got %0d want 0", StallCount); end
        tick();
        IF_IDUsesRt = 1;
        @(negedge clk);
        nchk++;
        if (outs !== LU_OUT) begin nbad++; $display("FAIL rt_match: got %b want %b", outs, LU_OUT); end
        tick();
    endtask

    task automatic test_flush();
        do_rst();
        ID_EXMemRead = 1; ID_EXRegisterRt = 5; IF_IDRegisterRs = 5; EXBranchTaken = 1;
        @(negedge clk);
        nchk++;
        if (outs !== 8'b1111_1100) begin nbad++; $display("FAIL flush_ctrl: got %b want 11111100", outs); end
        tick();
        set_idle();
        @(negedge clk);
        nchk++;
        if (FlushCount !== 1 || StallCount !== 0) begin
            nbad++;
            $display("FAIL flush_counts: got flush=%0d stall=%0d want 1 0", FlushCount, StallCount);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_rst();
        EX_MEMMemAccess = 1; DMemReady = 0; EXBranchTaken = 1;
        ID_EXMemRead = 1; ID_EXRegisterRt = 4; IF_IDRegisterRs = 4;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            nchk++;
            if (outs !== {7'b0000_001, (k > 1)}) begin
                nbad++;
                $display("FAIL freeze_c%0d: got %b want %b", k, outs, {7'b0000_001, (k > 1)});
            end
            tick();
        end
        DMemReady = 1;
        @(negedge clk);
        nchk++;
        if (outs !== 8'b1111_1101) begin nbad++; $display("FAIL wait_release: got %b want 11111101", outs); end
        tick();
        set_idle();
        @(negedge clk);
        nchk++;
        if (outs !== DEF_OUT || StallCount !== 3 || FlushCount !== 1) begin
            nbad++;
            $display("FAIL wait_after: got %b stall=%0d flush=%0d want %b 3 1", outs, StallCount, FlushCount, DEF_OUT);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_rst();
        EX_MEMMemAccess = 1; DMemReady = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            nchk++;
            if (MemTimeout !== (k >= 5)) begin
                nbad++;
                $display("FAIL timeout_c%0d: got %b want %b", k, MemTimeout, (k >= 5));
            end
            tick();
        end
        DMemReady = 1;
        tick();
        set_idle();
        @(negedge clk);
        nchk++;
        if (MemTimeout !== 1'b1 || outs !== DEF_OUT) begin
            nbad++;
            $display("FAIL timeout_sticky: got to=%b ctrl=%b want 1 %b", MemTimeout, outs, DEF_OUT);
        end
        #2 rst = 1;
        model_reset();
        #1;
        nchk++;
        if (MemTimeout !== 1'b0 || outs !== RST_OUT) begin
            nbad++;
            $display("FAIL timeout_async_clear: got to=%b ctrl=%b want 0 %b", MemTimeout, outs, RST_OUT);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_saturation();
        do_rst();
        for (int i = 0; i < 20; i++) begin
            ID_EXMemRead = 1; ID_EXRegisterRt = 9; IF_IDRegisterRs = 9;
            tick();
            set_idle();
            tick();
        end
        @(negedge clk);
        nchk++;
        if (StallCount !== CNT_W'(CMAX)) begin nbad++; $display("FAIL stall_sat: got %0d want %0d", StallCount, CMAX); end
        for (int i = 0; i < 18; i++) begin
            EXBranchTaken = 1;
            tick();
        end
        set_idle();
        @(negedge clk);
        nchk++;
        if (FlushCount !== CNT_W'(CMAX) || StallCount !== CNT_W'(CMAX)) begin
            nbad++;
            $display("FAIL flush_sat: got flush=%0d stall=%0d want %0d %0d", FlushCount, StallCount, CMAX, CMAX);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_rst();
        EX_MEMMemAccess = 1; DMemReady = 0;
        tick();
        tick();
        @(negedge clk);
        nchk++;
        if (MemWaitBusy !== 1'b1 || StallCount !== 2) begin
            nbad++;
            $display("FAIL mid_wait_busy: got busy=%b stall=%0d want 1 2", MemWaitBusy, StallCount);
        end
        #2 rst = 1;
        model_reset();
        #1;
        nchk++;
        if (outs !== RST_OUT || StallCount !== 0) begin
            nbad++;
            $display("FAIL mid_wait_rst: got %b stall=%0d want %b 0", outs, StallCount, RST_OUT);
        end
        tick();
        rst = 0;
        set_idle();
        @(negedge clk);
        nchk++;
        if (outs !== DEF_OUT) begin nbad++; $display("FAIL mid_wait_run: got %b want %b", outs, DEF_OUT); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp;
        do_rst();
        for (int i = 0; i < 600; i++) begin
            ID_EXMemRead    = 1'($urandom_range(0, 1));
            ID_EXRegisterRt = 5'($urandom_range(0, 3));
            IF_IDRegisterRs = 5'($urandom_range(0, 3));
            IF_IDRegisterRt = 5'($urandom_range(0, 3));
            IF_IDUsesRt     = 1'($urandom_range(0, 1));
            EXBranchTaken   = ($urandom_range(0, 3) == 0);
            EX_MEMMemAccess = ($urandom_range(0, 2) != 0);
            DMemReady       = ((i % 100) < 8) ? 1'b0 : ($urandom_range(0, 2) != 0);
            rst             = ($urandom_range(0, 99) == 0);
            if (rst) model_reset();
            @(negedge clk);
            exp = model_ctrl();
            nchk++;
            if (outs !== exp) begin nbad++; $display("FAIL rand_ctrl i=%0d: got %b want %b", i, outs, exp); end
            nchk++;
            if (StallCount !== CNT_W'(m_stall) || FlushCount !== CNT_W'(m_flush) || MemTimeout !== m_to) begin
                nbad++;
                $display("FAIL rand_regs i=%0d: got stall=%0d flush=%0d to=%b want %0d %0d %b",
                         i, StallCount, FlushCount, MemTimeout, m_stall, m_flush, m_to);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_flush();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage processor; companion to the EX-stage forwarding logic.
- Detects load-use hazards that forwarding cannot cover and inserts one bubble.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Freezes the whole pipeline while the data memory is not ready. Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before MemTimeout sets (1..255)
CNT_W, 16, width of StallCount and FlushCount

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-high
ID_EXMemRead  in  1  instruction in EX is a load
ID_EXRegisterRt  in  5  load destination register in EX
IF_IDRegisterRs  in  5  rs of instruction in ID
IF_IDRegisterRt  in  5  rt of instruction in ID
IF_IDUsesRt  in  1  ID instruction reads rt as a source
EXBranchTaken  in  1  branch/jump in EX resolved taken
EX_MEMMemAccess  in  1  instruction in MEM is a load or store
DMemReady  in  1  data memory completes access this cycle
PCWrite  out  1  PC update enable
IF_IDWrite  out  1  IF/ID register enable
IF_IDFlush  out  1  clear IF/ID to NOP
ID_EXWrite  out  1  ID/EX register enable
ID_EXBubble  out  1  load NOP into ID/EX (zero control)
EX_MEMWrite  out  1  EX/MEM register enable
MEM_WBBubble  out  1  load NOP into MEM/WB
MemWaitBusy  out  1  controller in MEM_WAIT state
MemTimeout  out  1  sticky: wait exceeded MEM_TIMEOUT
StallCount  out  CNT_W  cycles with PCWrite=0, saturating
FlushCount  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Registered state: fsm {RUN, MEM_WAIT}, wait counter (8 bits), MemTimeout, StallCount, FlushCount. All control outputs are combinational (Mealy) from state and inputs. Hazard response takes effect in the same cycle, with zero latency.
- Reset (rst=1, asynchronous): fsm=RUN, wait counter=0, MemTimeout=0, StallCount=0, FlushCount=0.
  - While rst=1, force PCWrite=IF_IDWrite=ID_EXWrite=EX_MEMWrite=0, IF_IDFlush=ID_EXBubble=MEM_WBBubble=1, MemWaitBusy=0.
  - Reset mid-wait abandons the wait; no counter update on that edge.
- memstall = EX_MEMMemAccess & ~DMemReady.
- loaduse = ID_EXMemRead & (ID_EXRegisterRt!=0) & ((ID_EXRegisterRt==IF_IDRegisterRs) | (IF_IDUsesRt & ID_EXRegisterRt==IF_IDRegisterRt)).
- Default (no event): all write enables 1, all flush/bubble 0.
- Priority, highest first:
  1. Freeze: when (fsm==RUN & memstall) or (fsm==MEM_WAIT & ~DMemReady), set PCWrite=IF_IDWrite=ID_EXWrite=EX_MEMWrite=0 and MEM_WBBubble=1. Suppress flush and bubble. The branch or hazard is held in place and re-evaluated after the freeze.
  2. Flush: on EXBranchTaken, set IF_IDFlush=1 and ID_EXBubble=1, with PCWrite=1 so the PC loads the target. Flush beats loaduse because the dependent instruction is discarded. FlushCount+1.
  3. Load-use: on loaduse, set PCWrite=0, IF_IDWrite=0, ID_EXBubble=1. This lasts one cycle; next cycle the load is in MEM, loaduse clears naturally, and forwarding supplies the operand.
- FSM transitions:
  - RUN -> MEM_WAIT when memstall; wait counter := 1.
  - MEM_WAIT stays while ~DMemReady; wait counter increments and saturates at 255.
  - When the wait counter reaches MEM_TIMEOUT, MemTimeout:=1. It stays sticky until rst; the FSM keeps waiting.
  - MEM_WAIT -> RUN in the cycle DMemReady=1. That cycle is not frozen, and priorities 2/3 apply normally. Wait counter := 0.
  - MemWaitBusy = (fsm==MEM_WAIT).
- StallCount increments on every clock edge with rst=0 and PCWrite=0. It saturates at 2^CNT_W-1 with no wrap; FlushCount likewise.
- Register $0 never produces a load-use stall.

Decomposition:
- Shared pipeline package/header: FSM state encodings (RUN=1'b0, MEM_WAIT=1'b1), register-index width constant (5), and NOP control constants reused by the bubble logic.
- One natural sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count). It is instantiated twice for StallCount and FlushCount.

Test Plan:
- Load-use: lw $3 in EX (ID_EXMemRead=1, Rt=3), ID Rs=3, DMemReady=1 -> one cycle PCWrite=0, IF_IDWrite=0, ID_EXBubble=1. Next cycle defaults resume; StallCount=1.
- Rt=0 or IF_IDUsesRt=0 with only an Rt match -> no stall; all write enables 1, StallCount unchanged.
- EXBranchTaken=1 together with loaduse -> IF_IDFlush=1, ID_EXBubble=1, PCWrite=1; FlushCount=1, StallCount=0.
- EX_MEMMemAccess=1, DMemReady low for 3 cycles then high -> 3 frozen cycles with MEM_WBBubble=1 and MemWaitBusy=1 for 2 cycles, 4th cycle unfrozen; StallCount=3.
- MEM_TIMEOUT=4, DMemReady held low 6 cycles -> MemTimeout rises at the 4th wait cycle and stays 1 after DMemReady; rst clears it asynchronously.
- CNT_W=2, 5 load-use stalls -> StallCount saturates at 3. Assert rst mid-MEM_WAIT -> outputs take reset values immediately; fsm=RUN.
